// File: rtl/reg_file_write_back.sv
// Write-side front end of the register file.
// Three result producers (load, mul/div, ALU) compete for one registered
// write port under fixed priority. A per-register busy scoreboard tracks
// outstanding writes so decode can detect RAW hazards on rs1/rs2.
//
// Handshake: a source asserts valid and holds rd/data stable until it sees
// ready. The transfer completes in the cycle where valid & ready are both
// high. Ready is purely combinational from the valids, and some valid source
// is accepted every cycle because the register file never stalls.

module reg_file_write_back #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sync_reset,

  input  logic                  src0_valid,
  input  logic [ADDR_WIDTH-1:0] src0_rd,
  input  logic [DATA_WIDTH-1:0] src0_data,
  output logic                  src0_ready,

  input  logic                  src1_valid,
  input  logic [ADDR_WIDTH-1:0] src1_rd,
  input  logic [DATA_WIDTH-1:0] src1_data,
  output logic                  src1_ready,

  input  logic                  src2_valid,
  input  logic [ADDR_WIDTH-1:0] src2_rd,
  input  logic [DATA_WIDTH-1:0] src2_data,
  output logic                  src2_ready,

  input  logic                  reserve_enable,
  input  logic [ADDR_WIDTH-1:0] reserve_addr,

  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,

  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data_in,

  output logic                  unexpected_wb,
  output logic                  idle
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_nonzero;
  logic                  do_write;

  // Fixed-priority grant: load beats mul/div beats ALU.
  always_comb begin
    src0_ready = src0_valid;
    src1_ready = src1_valid & ~src0_valid;
    src2_ready = src2_valid & ~src0_valid & ~src1_valid;
  end

  // Mux the granted source's destination and data onto the write path.
  always_comb begin
    accept   = src0_valid | src1_valid | src2_valid;
    sel_rd   = '0;
    sel_data = '0;
    if (src0_valid) begin
      sel_rd   = src0_rd;
      sel_data = src0_data;
    end else if (src1_valid) begin
      sel_rd   = src1_rd;
      sel_data = src1_data;
    end else if (src2_valid) begin
      sel_rd   = src2_rd;
      sel_data = src2_data;
    end
    // x0 writes complete the handshake but never touch the register file.
    sel_nonzero = (sel_rd != '0);
    do_write    = accept & sel_nonzero;
  end

  // Scoreboard update: clear on the accepted write, then apply the reserve
  // so a same-cycle reserve (the younger instruction) wins. x0 never busy.
  always_comb begin
    busy_next = busy;
    if (do_write) begin
      busy_next[sel_rd] = 1'b0;
    end
    if (reserve_enable && (reserve_addr != '0)) begin
      busy_next[reserve_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Registered write port, scoreboard state and the unexpected-write pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_enable  <= 1'b0;
      write_addr    <= '0;
      write_data_in <= '0;
      unexpected_wb <= 1'b0;
      busy          <= '0;
    end else if (sync_reset) begin
      write_enable  <= 1'b0;
      write_addr    <= '0;
      write_data_in <= '0;
      unexpected_wb <= 1'b0;
      busy          <= '0;
    end else begin
      write_enable  <= do_write;
      unexpected_wb <= do_write & ~busy[sel_rd];
      if (do_write) begin
        write_addr    <= sel_rd;
        write_data_in <= sel_data;
      end
      busy <= busy_next;
    end
  end

  // Hazard lookups read current state only; same-cycle activity is covered
  // by register file read forwarding.
  always_comb begin
    rs1_busy = busy[rs1_addr];
    rs2_busy = busy[rs2_addr];
    idle     = ~|busy & ~src0_valid & ~src1_valid & ~src2_valid & ~write_enable;
  end

endmodule

// File: tb/tb_reg_file_write_back.sv
// Directed bench for reg_file_write_back: reset, reserve/write-back,
// priority ordering, reserve/write collision, x0 writes, unexpected writes,
// async and sync reset mid-operation.

module tb_reg_file_write_back;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic          sync_reset;
  logic          src0_valid, src1_valid, src2_valid;
  logic [AW-1:0] src0_rd, src1_rd, src2_rd;
  logic [DW-1:0] src0_data, src1_data, src2_data;
  logic          src0_ready, src1_ready, src2_ready;
  logic          reserve_enable;
  logic [AW-1:0] reserve_addr;
  logic [AW-1:0] rs1_addr, rs2_addr;
  logic          rs1_busy, rs2_busy;
  logic          write_enable;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data_in;
  logic          unexpected_wb;
  logic          idle;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_q[$];

  reg_file_write_back #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .sync_reset(sync_reset),
    .src0_valid(src0_valid), .src0_rd(src0_rd), .src0_data(src0_data), .src0_ready(src0_ready),
    .src1_valid(src1_valid), .src1_rd(src1_rd), .src1_data(src1_data), .src1_ready(src1_ready),
    .src2_valid(src2_valid), .src2_rd(src2_rd), .src2_data(src2_data), .src2_ready(src2_ready),
    .reserve_enable(reserve_enable), .reserve_addr(reserve_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .write_enable(write_enable), .write_addr(write_addr), .write_data_in(write_data_in),
    .unexpected_wb(unexpected_wb), .idle(idle)
  );

  // Clock and timeout guard
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reserve(input logic [AW-1:0] a);
    reserve_enable = 1'b1;
    reserve_addr   = a;
    tick();
    reserve_enable = 1'b0;
    reserve_addr   = '0;
  endtask

  initial begin
    logic [AW-1:0] e;
    reset = 1'b1; sync_reset = 1'b0;
    src0_valid = 0; src1_valid = 0; src2_valid = 0;
    src0_rd = '0; src1_rd = '0; src2_rd = '0;
    src0_data = '0; src1_data = '0; src2_data = '0;
    reserve_enable = 1'b0; reserve_addr = '0;
    rs1_addr = 5'd5; rs2_addr = 5'd0;

    // Reset held 3 cycles
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_we", write_enable, 0);
    check("rst_idle", idle, 1);
    check("rst_unexp", unexpected_wb, 0);
    check("rst_busy5", rs1_busy, 0);

    // Reserve x5, ALU write two cycles later
    reserve(5'd5);
    check("res5_busy", rs1_busy, 1);
    check("res5_idle", idle, 0);
    tick();
    src2_valid = 1; src2_rd = 5'd5; src2_data = 32'h1234_5678;
    #1;
    check("x5_ready2", src2_ready, 1);
    check("x5_busy_pre", rs1_busy, 1);
    tick();
    src2_valid = 0;
    check("x5_we", write_enable, 1);
    check("x5_addr", write_addr, 5);
    check("x5_data", write_data_in, 32'h1234_5678);
    check("x5_busy_post", rs1_busy, 0);
    check("x5_unexp", unexpected_wb, 0);
    tick();
    check("x5_we_drop", write_enable, 0);
    check("x5_idle", idle, 1);

    // Priority: three sources valid together
    reserve(5'd3); reserve(5'd4); reserve(5'd6);
    src0_valid = 1; src0_rd = 5'd3; src0_data = 32'h0000_0003;
    src1_valid = 1; src1_rd = 5'd4; src1_data = 32'h0000_0004;
    src2_valid = 1; src2_rd = 5'd6; src2_data = 32'h0000_0006;
    exp_q.push_back(5'd3); exp_q.push_back(5'd4); exp_q.push_back(5'd6);
    #1;
    check("pri_r0", src0_ready, 1);
    check("pri_r1", src1_ready, 0);
    check("pri_r2", src2_ready, 0);
    tick();
    src0_valid = 0;
    e = exp_q.pop_front();
    check("pri_we0", write_enable, 1);
    check("pri_addr0", write_addr, e);
    #1;
    check("pri_r1b", src1_ready, 1);
    check("pri_r2b", src2_ready, 0);
    tick();
    src1_valid = 0;
    e = exp_q.pop_front();
    check("pri_we1", write_enable, 1);
    check("pri_addr1", write_addr, e);
    check("pri_data1", write_data_in, 32'h0000_0004);
    #1;
    check("pri_r2c", src2_ready, 1);
    tick();
    src2_valid = 0;
    e = exp_q.pop_front();
    check("pri_we2", write_enable, 1);
    check("pri_addr2", write_addr, e);
    check("pri_unexp", unexpected_wb, 0);
    rs1_addr = 5'd3; rs2_addr = 5'd6;
    #1;
    check("pri_busy3", rs1_busy, 0);
    check("pri_busy6", rs2_busy, 0);

    // Same-cycle reserve and write to x7
    reserve(5'd7);
    reserve_enable = 1; reserve_addr = 5'd7;
    src1_valid = 1; src1_rd = 5'd7; src1_data = 32'h0000_A5A5;
    tick();
    reserve_enable = 0; src1_valid = 0;
    rs2_addr = 5'd7;
    #1;
    check("col_we", write_enable, 1);
    check("col_addr", write_addr, 7);
    check("col_data", write_data_in, 32'h0000_A5A5);
    check("col_busy7", rs2_busy, 1);
    check("col_unexp", unexpected_wb, 0);

    // x0 write: handshake only
    src2_valid = 1; src2_rd = 5'd0; src2_data = 32'hFFFF_FFFF;
    #1;
    check("x0_ready", src2_ready, 1);
    tick();
    src2_valid = 0;
    check("x0_we", write_enable, 0);
    check("x0_unexp", unexpected_wb, 0);
    check("x0_busy7", rs2_busy, 1);

    // Unreserved write to x9
    src2_valid = 1; src2_rd = 5'd9; src2_data = 32'h0000_0099;
    tick();
    src2_valid = 0;
    check("x9_we", write_enable, 1);
    check("x9_addr", write_addr, 9);
    check("x9_unexp", unexpected_wb, 1);
    tick();
    check("x9_unexp_drop", unexpected_wb, 0);
    check("x9_we_drop", write_enable, 0);

    // Async reset mid-operation with src1 pending to x10
    reserve(5'd10);
    rs1_addr = 5'd10;
    src1_valid = 1; src1_rd = 5'd10; src1_data = 32'h0000_0010;
    #1;
    check("ar_busy10_pre", rs1_busy, 1);
    reset = 1'b1;
    #1;
    check("ar_busy10", rs1_busy, 0);
    check("ar_busy7", rs2_busy, 0);
    check("ar_we", write_enable, 0);
    check("ar_ready1", src1_ready, 1);
    tick();
    check("ar_we_hold", write_enable, 0);
    check("ar_busy10_hold", rs1_busy, 0);
    reset = 1'b0; src1_valid = 0;
    #1;
    check("ar_idle", idle, 1);
    tick();
    check("ar_idle2", idle, 1);
    check("ar_unexp", unexpected_wb, 0);

    // Synchronous clear drops a reservation on the next edge
    reserve(5'd12);
    rs1_addr = 5'd12;
    #1;
    check("sr_busy_pre", rs1_busy, 1);
    sync_reset = 1'b1;
    tick();
    sync_reset = 1'b0;
    check("sr_busy", rs1_busy, 0);
    check("sr_idle", idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
